// File: rtl/decode38_pkg.sv
// Shared types and helpers for the 3-to-8 decoder lab block.
package decode38_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } st_t;

    function automatic logic [7:0] onehot8(input logic [2:0] code);
        return 8'b0000_0001 << code;
    endfunction

endpackage

// File: rtl/decode38_scan_seg7.sv
// Hex digit to 7-segment pattern, active-high, bit order {dp,g,f,e,d,c,b,a}.
module seg7 (
    input  logic [3:0] seg_in,
    output logic [7:0] seg_out
);

    always_comb begin
        seg_out = 8'h00;
        unique case (seg_in)
            4'h0: seg_out = 8'h3F;
            4'h1: seg_out = 8'h06;
            4'h2: seg_out = 8'h5B;
            4'h3: seg_out = 8'h4F;
            4'h4: seg_out = 8'h66;
            4'h5: seg_out = 8'h6D;
            4'h6: seg_out = 8'h7D;
            4'h7: seg_out = 8'h07;
            4'h8: seg_out = 8'h7F;
            4'h9: seg_out = 8'h6F;
            4'hA: seg_out = 8'h77;
            4'hB: seg_out = 8'h7C;
            4'hC: seg_out = 8'h39;
            4'hD: seg_out = 8'h5E;
            4'hE: seg_out = 8'h79;
            4'hF: seg_out = 8'h71;
            default: seg_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/decode38_scan.sv
// Registered 3-to-8 decoder with load capture, prescaled auto-scan and
// a 7-segment readout of the held code.
module decode38_scan
    import decode38_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] code,
    output logic [7:0] y,
    output logic [2:0] code_out,
    output logic       valid,
    output logic [7:0] seg_out
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    st_t              st, st_nxt;
    logic [2:0]       code_q, code_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_q;
    logic             load_rise;
    logic [7:0]       y_q, y_nxt;
    logic             valid_q, valid_nxt;

    assign load_rise = load & ~load_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= OFF;
            code_q  <= '0;
            cnt     <= '0;
            load_q  <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            st      <= st_nxt;
            code_q  <= code_nxt;
            cnt     <= cnt_nxt;
            load_q  <= load;
            y_q     <= y_nxt;
            valid_q <= valid_nxt;
        end
    end

    // Actions follow the state being entered on this edge, so en/mode
    // changes take effect on the very next edge.
    always_comb begin
        st_nxt    = !en ? OFF : (mode ? SCAN : DIRECT);
        code_nxt  = code_q;
        cnt_nxt   = '0;
        y_nxt     = '0;
        valid_nxt = 1'b0;
        unique case (st_nxt)
            DIRECT: begin
                if (load_rise)
                    code_nxt = code;
            end
            SCAN: begin
                if (load_rise) begin
                    code_nxt = code;
                end else if (st != SCAN) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_MAX) begin
                    code_nxt = dir ? code_q - 3'd1 : code_q + 3'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: ;
        endcase
        if (st_nxt != OFF) begin
            y_nxt     = onehot8(code_nxt);
            valid_nxt = 1'b1;
        end
    end

    assign y        = y_q;
    assign valid    = valid_q;
    assign code_out = code_q;

    seg7 seg7_decode38 (
        .seg_in  ({1'b0, code_out}),
        .seg_out (seg_out)
    );

endmodule

// File: tb/tb_decode38_scan.sv
// Directed self-checking bench for decode38_scan with a short scan period.
module tb_decode38_scan;

    logic       clk = 1'b0;
    logic       rst, en, mode, dir, load;
    logic [2:0] code;
    logic [7:0] y, seg_out;
    logic [2:0] code_out;
    logic       valid;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    decode38_scan #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .code     (code),
        .y        (y),
        .code_out (code_out),
        .valid    (valid),
        .seg_out  (seg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] c, input logic [7:0] yy, input logic v);
        check({tag, ".code_out"}, 32'(code_out), 32'(c));
        check({tag, ".y"},        32'(y),        32'(yy));
        check({tag, ".valid"},    32'(valid),    32'(v));
    endtask

    logic [2:0] up_seq [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [7:0] up_y   [4] = '{8'h40, 8'h80, 8'h01, 8'h02};

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; dir = 1'b0; load = 1'b0; code = 3'd0;
        #3;
        expect_out("reset", 3'd0, 8'h00, 1'b0);
        check("reset.seg", 32'(seg_out), 32'h3F);
        step(2);
        rst = 1'b0;
        step(1);
        expect_out("post_reset", 3'd0, 8'h01, 1'b1);

        // DIRECT capture and held load
        code = 3'd5; load = 1'b1;
        step(1);
        expect_out("load5", 3'd5, 8'h20, 1'b1);
        check("load5.seg", 32'(seg_out), 32'h6D);
        code = 3'd2;
        step(2);
        expect_out("load_held", 3'd5, 8'h20, 1'b1);
        load = 1'b0;
        step(1);
        code = 3'd6; load = 1'b1;
        step(1);
        load = 1'b0;
        expect_out("load6", 3'd6, 8'h40, 1'b1);

        // SCAN up: entry edge, then a step every 4 edges
        mode = 1'b1; dir = 1'b0;
        step(1);
        expect_out("scan_entry", 3'd6, 8'h40, 1'b1);
        for (int i = 1; i < 4; i++) begin
            step(3);
            check("scan_up.hold", 32'(code_out), 32'(up_seq[i-1]));
            step(1);
            expect_out("scan_up", up_seq[i], up_y[i], 1'b1);
        end

        // Load in SCAN to 0, then scan down wraps to 7
        code = 3'd0; load = 1'b1;
        step(1);
        load = 1'b0; dir = 1'b1;
        expect_out("scan_load0", 3'd0, 8'h01, 1'b1);
        step(3);
        check("scan_dn.hold", 32'(code_out), 32'd0);
        step(1);
        expect_out("scan_dn", 3'd7, 8'h80, 1'b1);

        // Load rising edge coincides with tick: load wins
        dir = 1'b0;
        step(3);
        code = 3'd3; load = 1'b1;
        step(1);
        load = 1'b0;
        expect_out("collide", 3'd3, 8'h08, 1'b1);
        step(3);
        check("collide.hold", 32'(code_out), 32'd3);
        step(1);
        expect_out("collide.next", 3'd4, 8'h10, 1'b1);

        // Enable drop holds code, ignores load; re-entry restarts prescaler
        en = 1'b0;
        step(1);
        expect_out("en_off", 3'd4, 8'h00, 1'b0);
        check("en_off.seg", 32'(seg_out), 32'h66);
        code = 3'd2; load = 1'b1;
        step(1);
        load = 1'b0;
        check("off_load_ignored", 32'(code_out), 32'd4);
        step(1);
        en = 1'b1;
        step(1);
        expect_out("en_on", 3'd4, 8'h10, 1'b1);
        step(3);
        check("en_on.hold", 32'(code_out), 32'd4);
        step(1);
        expect_out("en_on.step", 3'd5, 8'h20, 1'b1);

        // Asynchronous reset mid-scan
        step(2);
        #2;
        rst = 1'b1;
        #1;
        expect_out("rst_mid", 3'd0, 8'h00, 1'b0);
        check("rst_mid.seg", 32'(seg_out), 32'h3F);
        step(1);
        rst = 1'b0;
        step(1);
        expect_out("rst_rel", 3'd0, 8'h01, 1'b1);
        step(3);
        check("rst_rel.hold", 32'(code_out), 32'd0);
        step(1);
        expect_out("rst_rel.step", 3'd1, 8'h02, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
